// File: rtl/echip65_pkg.sv
// Shared constants and helpers for the 2nd-order sigma-delta DAC: full-scale value,
// monitor select encodings and the guard-bit rule for saturating accumulators.
package echip65_pkg;

    localparam int unsigned MON_W       = 16;
    localparam int unsigned SAT_GUARD_W = 2;

    typedef enum logic [3:0] {
        MON_ACC1   = 4'd0,
        MON_ACC2   = 4'd1,
        MON_ACTIVE = 4'd2,
        MON_STATUS = 4'd3
    } mon_sel_e;

    // Two guard bits hold acc + a - b without wrap when all three fit in w bits.
    function automatic int unsigned sat_sum_w(input int unsigned w);
        return w + SAT_GUARD_W;
    endfunction

    // Full scale of a signed data_w-bit sample.
    function automatic longint fs_of(input int unsigned data_w);
        return longint'(1) << (data_w - 1);
    endfunction

endpackage

// File: rtl/sdm2_sat_acc.sv
// Saturating accumulate step: next = clamp(acc + add - sub) to the signed W-bit range.
module sdm2_sat_acc
    import echip65_pkg::*;
#(
    parameter int unsigned W = 18
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W-1:0] add,
    input  logic signed [W-1:0] sub,
    output logic signed [W-1:0] acc_next_c
);

    localparam int unsigned SW = sat_sum_w(W);
    localparam logic signed [SW-1:0] MAX_V = (SW'(1) <<< (W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MIN_V = -(SW'(1) <<< (W - 1));

    logic signed [SW-1:0] sum_c;

    always_comb begin
        sum_c = SW'(acc) + SW'(add) - SW'(sub);
        if (sum_c > MAX_V) begin
            acc_next_c = W'(MAX_V);
        end else if (sum_c < MIN_V) begin
            acc_next_c = W'(MIN_V);
        end else begin
            acc_next_c = W'(sum_c);
        end
    end

endmodule

// File: rtl/sdm2_dac.sv
// Second-order CIFB sigma-delta DAC: one-deep sample buffer feeding an active sample
// that is re-read once per 2^OSR_LOG2 modulator clocks, 1-bit registered bitstream out.
module sdm2_dac
    import echip65_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned OSR_LOG2 = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              underflow,
    input  logic [3:0]        digital_monitor_sel,
    output logic [MON_W-1:0]  monitor_out
);

    localparam int unsigned ACC1_W = DATA_W + 2;
    localparam int unsigned ACC2_W = DATA_W + 4;
    localparam logic signed [ACC1_W-1:0] FS1 = ACC1_W'(fs_of(DATA_W));
    localparam logic signed [ACC2_W-1:0] FS2 = ACC2_W'(fs_of(DATA_W));

    logic [OSR_LOG2-1:0]       counter;
    logic [DATA_W-1:0]         pending;
    logic                      pending_full;
    logic signed [DATA_W-1:0]  active;
    logic signed [ACC1_W-1:0]  acc1;
    logic signed [ACC2_W-1:0]  acc2;

    logic                      load_c;
    logic                      handshake_c;
    logic signed [ACC1_W-1:0]  x1_c;
    logic signed [ACC1_W-1:0]  fb1_c;
    logic signed [ACC2_W-1:0]  fb2_c;
    logic signed [ACC2_W-1:0]  acc1_ext_c;
    logic signed [ACC1_W-1:0]  acc1_next_c;
    logic signed [ACC2_W-1:0]  acc2_next_c;
    logic [MON_W-1:0]          mon_c;

    assign load_c      = enable && (counter == '1);
    assign in_ready    = ~pending_full | load_c;
    assign handshake_c = in_valid & in_ready;

    // Handshake side keeps running while the modulator is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (handshake_c) begin
            pending      <= in_data;
            pending_full <= 1'b1;
        end else if (load_c) begin
            pending_full <= 1'b0;
        end
    end

    // Frame counter and active sample; an empty buffer at the boundary repeats the old sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= '0;
            active    <= '0;
            underflow <= 1'b0;
        end else if (enable) begin
            counter <= counter + OSR_LOG2'(1);
            if (load_c) begin
                if (pending_full) begin
                    active <= pending;
                end else begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    assign x1_c       = ACC1_W'(active);
    assign fb1_c      = dout ? FS1 : -FS1;
    assign fb2_c      = dout ? FS2 : -FS2;
    assign acc1_ext_c = ACC2_W'(acc1);

    sdm2_sat_acc #(.W(ACC1_W)) u_acc1 (
        .acc        (acc1),
        .add        (x1_c),
        .sub        (fb1_c),
        .acc_next_c (acc1_next_c)
    );

    sdm2_sat_acc #(.W(ACC2_W)) u_acc2 (
        .acc        (acc2),
        .add        (acc1_ext_c),
        .sub        (fb2_c),
        .acc_next_c (acc2_next_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc1 <= '0;
            acc2 <= '0;
            dout <= 1'b0;
        end else if (enable) begin
            acc1 <= acc1_next_c;
            acc2 <= acc2_next_c;
            dout <= ~acc2_next_c[ACC2_W-1];
        end
    end

    always_comb begin
        mon_c = '0;
        case (digital_monitor_sel)
            MON_ACC1:   mon_c = acc1[ACC1_W-1 -: MON_W];
            MON_ACC2:   mon_c = acc2[ACC2_W-1 -: MON_W];
            MON_ACTIVE: mon_c = active[DATA_W-1 -: MON_W];
            MON_STATUS: mon_c = MON_W'({counter, pending_full, underflow, dout});
            default:    mon_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_out <= '0;
        end else begin
            monitor_out <= mon_c;
        end
    end

endmodule

// File: tb/tb_sdm2_dac.sv
// Randomized scoreboard bench for sdm2_dac against an integer-arithmetic reference model.
module tb_sdm2_dac;

    localparam longint FS     = 32768;
    localparam longint A1_MAX = 131071;
    localparam longint A1_MIN = -131072;
    localparam longint A2_MAX = 524287;
    localparam longint A2_MIN = -524288;
    localparam int     FRAME  = 64;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = 16'h0000;
    logic [3:0]  sel      = 4'd0;
    logic        in_ready;
    logic        dout;
    logic        underflow;
    logic [15:0] monitor_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        dout;
        logic        uf;
        logic [15:0] mon;
    } exp_t;

    exp_t q[$];

    longint m_acc1 = 0, m_acc2 = 0, m_active = 0, m_pend = 0;
    int     m_cnt  = 0;
    bit     m_pf = 1'b0, m_uf = 1'b0, m_dout = 1'b0;

    logic [15:0] lvl [5];
    int          lo_b [5];
    int          hi_b [5];

    always #5 clk = ~clk;

    sdm2_dac #(.DATA_W(16), .OSR_LOG2(6)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .enable              (enable),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .dout                (dout),
        .underflow           (underflow),
        .digital_monitor_sel (sel),
        .monitor_out         (monitor_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Observable monitor value: top 16 bits taken arithmetically from the model state.
    function automatic logic [15:0] mon_of(input logic [3:0] s);
        case (s)
            4'd0:    return 16'(m_acc1 >>> 2);
            4'd1:    return 16'(m_acc2 >>> 4);
            4'd2:    return 16'(m_active);
            4'd3:    return 16'(m_cnt * 8 + int'(m_pf) * 4 + int'(m_uf) * 2 + int'(m_dout));
            default: return 16'h0000;
        endcase
    endfunction

    // Reference model: one update per clock, expected outputs pushed to the scoreboard.
    always @(posedge clk) begin
        exp_t   e;
        longint fb;
        bit     ld;
        bit     hs;
        if (!reset_n) begin
            m_acc1 = 0; m_acc2 = 0; m_active = 0; m_pend = 0;
            m_cnt = 0; m_pf = 1'b0; m_uf = 1'b0; m_dout = 1'b0;
            e.mon = 16'h0000;
        end else begin
            e.mon = mon_of(sel);
            ld = enable && (m_cnt == FRAME - 1);
            hs = in_valid && (!m_pf || ld);
            if (enable) begin
                fb     = m_dout ? FS : -FS;
                m_acc2 = clamp(m_acc2 + m_acc1 - fb, A2_MIN, A2_MAX);
                m_acc1 = clamp(m_acc1 + m_active - fb, A1_MIN, A1_MAX);
                m_dout = (m_acc2 >= 0);
                if (ld) begin
                    if (m_pf) m_active = m_pend;
                    else      m_uf = 1'b1;
                end
                m_cnt = (m_cnt + 1) % FRAME;
            end
            if (hs) begin
                m_pend = longint'($signed(in_data));
                m_pf   = 1'b1;
            end else if (ld) begin
                m_pf = 1'b0;
            end
        end
        e.dout = m_dout;
        e.uf   = m_uf;
        q.push_back(e);
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("dout", 32'(dout), 32'(e.dout));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("monitor_out", 32'(monitor_out), 32'(e.mon));
        end
        chk("in_ready", 32'(in_ready), 32'(!m_pf || (enable && m_cnt == FRAME - 1)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        int hs_cnt;

        lvl[0] = 16'h0000; lo_b[0] = 2032; hi_b[0] = 2064;
        lvl[1] = 16'h4000; lo_b[1] = 3032; hi_b[1] = 3112;
        lvl[2] = 16'hC000; lo_b[2] = 984;  hi_b[2] = 1064;
        lvl[3] = 16'h7FFF; lo_b[3] = 4056; hi_b[3] = 4096;
        lvl[4] = 16'h8000; lo_b[4] = 0;    hi_b[4] = 40;

        // Reset values, monitor forced to zero for the datapath selects.
        for (int s = 0; s < 3; s++) begin
            sel = 4'(s);
            step();
            step();
            chk("rst_monitor", 32'(monitor_out), 32'd0);
        end
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        reset_n  = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b1;

        // Ones-density for constant inputs after settling.
        for (int i = 0; i < 5; i++) begin
            in_data = lvl[i];
            repeat (256) begin
                step();
                sel = 4'($urandom_range(0, 5));
            end
            ones = 0;
            repeat (4096) begin
                step();
                sel = 4'($urandom_range(0, 5));
                ones += int'(dout);
            end
            chk_rng($sformatf("density_%04h", lvl[i]), ones, lo_b[i], hi_b[i]);
        end
        chk("no_underflow_when_fed", 32'(underflow), 32'd0);

        // Backpressure: continuous valid gives exactly one accept per frame.
        hs_cnt = 0;
        repeat (10 * FRAME) begin
            in_data = 16'($urandom);
            sel     = 4'($urandom_range(0, 4));
            step();
            if (in_valid && in_ready) hs_cnt++;
        end
        chk("handshakes_per_10_frames", 32'(hs_cnt), 32'd10);

        // Starve the input for more than two frames.
        in_valid = 1'b0;
        repeat (3 * FRAME) begin
            step();
            sel = 4'($urandom_range(0, 3));
        end
        chk("underflow_set", 32'(underflow), 32'd1);
        in_valid = 1'b1;
        repeat (3 * FRAME) begin
            in_data = 16'($urandom);
            step();
        end
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Freeze the modulator while the buffer keeps accepting.
        sel    = 4'd3;
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        repeat (40) step();

        // Asynchronous mid-frame reset with a full buffer.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 32'd0);
        chk("async_rst_underflow", 32'(underflow), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_monitor", 32'(monitor_out), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        in_data = 16'h1234;
        repeat (FRAME + 8) step();
        chk("post_rst_underflow", 32'(underflow), 32'd0);

        // Randomized traffic, enable gaps and monitor selects.
        repeat (3000) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = 16'($urandom);
            enable   = ($urandom_range(0, 9) < 9);
            sel      = 4'($urandom_range(0, 15));
            step();
        end

        enable   = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
